pcm_mm_sched: RTL and testbench

Parametrised multi-CPU request scheduler for the PCM memory-mapped path. It generalises the single-channel PCM request register to `NUM_CPUS` independent CPU ports, each with a one-deep holding slot. A single arbitrated request at a time goes to the PCM memory side through a `schedule`/`resolved` handshake. Read data, or a timeout error, is returned to the granted CPU. It sits between the CPU cores and the PCM memory-mapped slave.

---
 rtl/pcm_mm_pkg.sv | 13 +
 rtl/pcm_mm_arbiter.sv | 56 +++++
 rtl/pcm_mm_sched.sv | 157 +++++++++++++++
 tb/tb_pcm_mm_sched.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcm_mm_pkg.sv
// rtl/pcm_mm_pkg.sv - shared FSM state type and default widths for the PCM multi-CPU scheduler
package pcm_mm_pkg;

  localparam int PCM_ADDR_W = 20;
  localparam int PCM_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } pcm_sched_state_e;

endpackage

// File: rtl/pcm_mm_arbiter.sv
// rtl/pcm_mm_arbiter.sv - combinational grant over busy slots; PCM_MM_SCHED_RR_EN selects round-robin
module pcm_mm_arbiter
  import pcm_mm_pkg::*;
#(
  parameter int NUM_CPUS = 4,
  parameter int IDX_W    = $clog2(NUM_CPUS)
) (
  input  logic [NUM_CPUS-1:0] busy,
`ifdef PCM_MM_SCHED_RR_EN
  input  logic [IDX_W-1:0]    ptr,
`endif
  output logic [NUM_CPUS-1:0] grant,
  output logic [IDX_W-1:0]    grant_idx
);

`ifdef PCM_MM_SCHED_RR_EN
  int               idx;
  logic [IDX_W-1:0] idx_b;
  logic             found;

  // Walk the slots starting at the pointer, wrapping at NUM_CPUS; the first busy slot wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    idx_b     = '0;
    for (int k = 0; k < NUM_CPUS; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_CPUS) begin
        idx = idx - NUM_CPUS;
      end
      idx_b = IDX_W'(idx);
      if (!found && busy[idx_b]) begin
        found        = 1'b1;
        grant[idx_b] = 1'b1;
        grant_idx    = idx_b;
      end
    end
  end
`else
  // Fixed priority: scan downwards so the lowest busy index is the last (winning) assignment.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    for (int i = NUM_CPUS - 1; i >= 0; i--) begin
      if (busy[i]) begin
        grant     = '0;
        grant[i]  = 1'b1;
        grant_idx = IDX_W'(i);
      end
    end
  end
`endif

endmodule

// File: rtl/pcm_mm_sched.sv
// rtl/pcm_mm_sched.sv - multi-CPU PCM request scheduler (PCM_MM_SCHED_RR_EN enables round-robin)
module pcm_mm_sched
  import pcm_mm_pkg::*;
#(
  parameter int NUM_CPUS  = 4,
  parameter int ADDR_W    = PCM_ADDR_W,
  parameter int DATA_W    = PCM_DATA_W,
  parameter int TIMEOUT_W = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_CPUS-1:0]              cpu_req,
  input  logic [NUM_CPUS-1:0]              cpu_write,
  input  logic [NUM_CPUS-1:0][ADDR_W-1:0]  cpu_addr,
  input  logic [NUM_CPUS-1:0][DATA_W-1:0]  cpu_data_in,
  output logic [NUM_CPUS-1:0]              cpu_busy,
  output logic [NUM_CPUS-1:0]              cpu_ready,
  output logic [NUM_CPUS-1:0]              cpu_err,
  output logic [NUM_CPUS-1:0][DATA_W-1:0]  cpu_data_out,
  output logic                             schedule,
  output logic [ADDR_W-1:0]                addr_reg,
  output logic                             mem_write,
  output logic [DATA_W-1:0]                mem_wdata,
  input  logic                             resolved,
  input  logic [DATA_W-1:0]                data_in
);

  localparam int IDX_W = $clog2(NUM_CPUS);

  pcm_sched_state_e                 state;
  logic [TIMEOUT_W-1:0]             wait_cnt;
  logic [TIMEOUT_W-1:0]             wait_cnt_nxt;
  logic                             timeout_hit;
  logic [IDX_W-1:0]                 cur_idx;

  logic [NUM_CPUS-1:0]              slot_write;
  logic [NUM_CPUS-1:0][ADDR_W-1:0]  slot_addr;
  logic [NUM_CPUS-1:0][DATA_W-1:0]  slot_data;

  logic [NUM_CPUS-1:0]              arb_grant;
  logic [IDX_W-1:0]                 arb_idx;
  logic                             sel_write;
  logic [ADDR_W-1:0]                sel_addr;
  logic [DATA_W-1:0]                sel_data;

`ifdef PCM_MM_SCHED_RR_EN
  logic [IDX_W-1:0]                 rr_ptr;
`endif

  // Timeout fires on the WAIT edge where the counter would reach all-ones.
  assign wait_cnt_nxt = wait_cnt + 1'b1;
  assign timeout_hit  = &wait_cnt_nxt;

  pcm_mm_arbiter #(
    .NUM_CPUS (NUM_CPUS),
    .IDX_W    (IDX_W)
  ) u_arbiter (
    .busy      (cpu_busy),
`ifdef PCM_MM_SCHED_RR_EN
    .ptr       (rr_ptr),
`endif
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  // Holding slots: a free slot latches its request fields; a busy slot ignores new strobes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_write <= '0;
      slot_addr  <= '0;
      slot_data  <= '0;
    end else begin
      for (int i = 0; i < NUM_CPUS; i++) begin
        if (cpu_req[i] && !cpu_busy[i]) begin
          slot_write[i] <= cpu_write[i];
          slot_addr[i]  <= cpu_addr[i];
          slot_data[i]  <= cpu_data_in[i];
        end
      end
    end
  end

  // One-hot AND-OR select of the granted slot's fields.
  always_comb begin
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_data  = '0;
    for (int i = 0; i < NUM_CPUS; i++) begin
      sel_write = sel_write | (slot_write[i] & arb_grant[i]);
      sel_addr  = sel_addr  | (slot_addr[i] & {ADDR_W{arb_grant[i]}});
      sel_data  = sel_data  | (slot_data[i] & {DATA_W{arb_grant[i]}});
    end
  end

  // Scheduler FSM: grant in IDLE, hold schedule in WAIT until resolve/timeout, pulse response in RESP.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      schedule     <= 1'b0;
      addr_reg     <= '0;
      mem_write    <= 1'b0;
      mem_wdata    <= '0;
      wait_cnt     <= '0;
      cur_idx      <= '0;
      cpu_busy     <= '0;
      cpu_ready    <= '0;
      cpu_err      <= '0;
      cpu_data_out <= '0;
`ifdef PCM_MM_SCHED_RR_EN
      rr_ptr       <= '0;
`endif
    end else begin
      cpu_busy <= cpu_busy | (cpu_req & ~cpu_busy);
      case (state)
        IDLE: begin
          if (|cpu_busy) begin
            schedule  <= 1'b1;
            addr_reg  <= sel_addr;
            mem_write <= sel_write;
            mem_wdata <= sel_data;
            cur_idx   <= arb_idx;
            wait_cnt  <= '0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          wait_cnt <= wait_cnt_nxt;
          if (resolved) begin
            schedule <= 1'b0;
            if (!mem_write) begin
              cpu_data_out[cur_idx] <= data_in;
            end
            cpu_ready[cur_idx] <= 1'b1;
            cpu_busy[cur_idx]  <= 1'b0;
            state              <= RESP;
          end else if (timeout_hit) begin
            schedule           <= 1'b0;
            cpu_ready[cur_idx] <= 1'b1;
            cpu_err[cur_idx]   <= 1'b1;
            cpu_busy[cur_idx]  <= 1'b0;
            state              <= RESP;
          end
        end
        RESP: begin
          cpu_ready <= '0;
          cpu_err   <= '0;
`ifdef PCM_MM_SCHED_RR_EN
          rr_ptr    <= (cur_idx == IDX_W'(NUM_CPUS - 1)) ? '0 : cur_idx + 1'b1;
`endif
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pcm_mm_sched.sv
// tb/tb_pcm_mm_sched.sv - directed and randomized checks of pcm_mm_sched against a transaction-level model
`timescale 1ns/1ps
module tb_pcm_mm_sched;

  localparam int N  = 4;
  localparam int AW = 20;
  localparam int DW = 16;
  localparam int TW = 8;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [N-1:0]            cpu_req;
  logic [N-1:0]            cpu_write;
  logic [N-1:0][AW-1:0]    cpu_addr;
  logic [N-1:0][DW-1:0]    cpu_data_in;
  logic [N-1:0]            cpu_busy;
  logic [N-1:0]            cpu_ready;
  logic [N-1:0]            cpu_err;
  logic [N-1:0][DW-1:0]    cpu_data_out;
  logic                    schedule;
  logic [AW-1:0]           addr_reg;
  logic                    mem_write;
  logic [DW-1:0]           mem_wdata;
  logic                    resolved;
  logic [DW-1:0]           data_in;

  always #5 clk = ~clk;

  pcm_mm_sched #(
    .NUM_CPUS  (N),
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .TIMEOUT_W (TW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_req      (cpu_req),
    .cpu_write    (cpu_write),
    .cpu_addr     (cpu_addr),
    .cpu_data_in  (cpu_data_in),
    .cpu_busy     (cpu_busy),
    .cpu_ready    (cpu_ready),
    .cpu_err      (cpu_err),
    .cpu_data_out (cpu_data_out),
    .schedule     (schedule),
    .addr_reg     (addr_reg),
    .mem_write    (mem_write),
    .mem_wdata    (mem_wdata),
    .resolved     (resolved),
    .data_in      (data_in)
  );

  int checks = 0;
  int errors = 0;

  // Transaction-level model: pending slots, their fields, last read data, arbitration pointer.
  logic [N-1:0]  m_pend;
  logic [N-1:0]  m_wr;
  logic [AW-1:0] m_addr [N];
  logic [DW-1:0] m_data [N];
  logic [DW-1:0] m_dout [N];
  int            m_ptr;
  int            m_cur;

  logic [N-1:0][AW-1:0] ta;
  logic [N-1:0][DW-1:0] td;
  int                   gobs;
  int                   exp_ord [$];
  logic [DW-1:0]        saved;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_reset();
    m_pend = '0;
    m_wr   = '0;
    m_ptr  = 0;
    m_cur  = -1;
    for (int i = 0; i < N; i++) m_dout[i] = '0;
  endtask

  function automatic int pick();
    int r;
    r = -1;
`ifdef PCM_MM_SCHED_RR_EN
    for (int k = N - 1; k >= 0; k--) if (m_pend[(m_ptr + k) % N]) r = (m_ptr + k) % N;
`else
    for (int k = N - 1; k >= 0; k--) if (m_pend[k]) r = k;
`endif
    return r;
  endfunction

  task automatic check_dout();
    for (int i = 0; i < N; i++) chk($sformatf("dout%0d", i), cpu_data_out[i], m_dout[i]);
  endtask

  task automatic issue(input logic [N-1:0] mask, input logic [N-1:0] wr,
                       input logic [N-1:0][AW-1:0] a, input logic [N-1:0][DW-1:0] d);
    cpu_req     = mask;
    cpu_write   = wr;
    cpu_addr    = a;
    cpu_data_in = d;
    for (int i = 0; i < N; i++) begin
      if (mask[i] && !m_pend[i]) begin
        m_pend[i] = 1'b1;
        m_wr[i]   = wr[i];
        m_addr[i] = a[i];
        m_data[i] = d[i];
      end
    end
    tick();
    cpu_req = '0;
  endtask

  // Act as the PCM side for one transaction; optionally re-request a port during RESP.
  task automatic serve(input int delay, input logic [DW-1:0] rdata, input int rerq, output int gobs_o);
    int g;
    int k;
    gobs_o = -1;
    k = 0;
    while (schedule !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    chk("sched_up", schedule, 1);
    g = (m_cur >= 0) ? m_cur : pick();
    m_cur = -1;
    if (g < 0) return;
    chk("busy_at_grant", cpu_busy, m_pend);
    chk("addr_reg", addr_reg, m_addr[g]);
    chk("mem_write", mem_write, m_wr[g]);
    if (m_wr[g]) chk("mem_wdata", mem_wdata, m_data[g]);
    for (int i = 0; i < N; i++) if (m_pend[i] && m_addr[i] == addr_reg) gobs_o = i;
    for (int t = 0; t < delay; t++) tick();
    chk("sched_hold", schedule, 1);
    chk("no_early_ready", cpu_ready, 0);
    resolved = 1'b1;
    data_in  = rdata;
    tick();
    resolved = 1'b0;
    data_in  = DW'($urandom);
    chk("ready_pulse", cpu_ready, 4'b0001 << g);
    chk("err_clear", cpu_err, 0);
    chk("sched_drop", schedule, 0);
    m_pend[g] = 1'b0;
    if (!m_wr[g]) m_dout[g] = rdata;
    m_ptr = (g + 1) % N;
    chk("busy_after", cpu_busy, m_pend);
    check_dout();
    if (rerq >= 0) begin
      cpu_req[rerq]     = 1'b1;
      cpu_write[rerq]   = 1'($urandom);
      cpu_addr[rerq]    = AW'(rerq);
      cpu_data_in[rerq] = DW'($urandom);
      if (!m_pend[rerq]) begin
        m_pend[rerq] = 1'b1;
        m_wr[rerq]   = cpu_write[rerq];
        m_addr[rerq] = cpu_addr[rerq];
        m_data[rerq] = cpu_data_in[rerq];
      end
    end
    tick();
    cpu_req = '0;
    chk("ready_one_cycle", cpu_ready, 0);
    chk("err_one_cycle", cpu_err, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b0;
    cpu_req     = '0;
    cpu_write   = '0;
    cpu_addr    = '0;
    cpu_data_in = '0;
    resolved    = 1'b0;
    data_in     = '0;
    model_reset();
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_schedule", schedule, 0);
    chk("rst_busy", cpu_busy, 0);
    chk("rst_ready", cpu_ready, 0);
    chk("rst_err", cpu_err, 0);
    chk("rst_addr", addr_reg, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_dout", cpu_data_out, 0);
    reset = 1'b1;
    tick();
    chk("post_rst_sched", schedule, 0);

    // Contention: all ports at once, immediate resolve, port 0 re-requests in RESP three times
`ifdef PCM_MM_SCHED_RR_EN
    exp_ord = '{0, 1, 2, 3, 0};
`else
    exp_ord = '{0, 0, 0, 0, 1, 2, 3};
`endif
    for (int i = 0; i < N; i++) begin
      ta[i] = AW'(i);
      td[i] = DW'($urandom);
    end
    issue(4'hF, 4'h0, ta, td);
    for (int t = 0; t < exp_ord.size(); t++) begin
      serve(0, DW'($urandom), (t < 3) ? 0 : -1, gobs);
      chk($sformatf("cont_grant%0d", t), gobs, exp_ord[t]);
    end
    chk("cont_drained", cpu_busy, 0);

    // Single read on port 2 with minimum-latency checks
    ta    = '0;
    ta[2] = 20'hFFFFF;
    issue(4'b0100, 4'b0000, ta, td);
    chk("rd_sched_e0", schedule, 0);
    chk("rd_busy2", cpu_busy, 4'b0100);
    tick();
    chk("rd_sched_e1", schedule, 1);
    chk("rd_addr", addr_reg, 20'hFFFFF);
    serve(2, 16'h0FF0, -1, gobs);
    chk("rd_dout2", cpu_data_out[2], 16'h0FF0);

    // Write on port 0: data goes out, nothing comes back
    saved = m_dout[0];
    ta[0] = AW'($urandom);
    td[0] = 16'hA5A5;
    issue(4'b0001, 4'b0001, ta, td);
    tick();
    chk("wr_mem_write", mem_write, 1);
    chk("wr_wdata", mem_wdata, 16'hA5A5);
    serve(1, 16'h1234, -1, gobs);
    chk("wr_dout0_kept", cpu_data_out[0], saved);

    // Request while busy is ignored; another port is captured during WAIT
    ta[3] = 20'h12345;
    issue(4'b1000, 4'b0000, ta, td);
    ta[3] = 20'h54321;
    issue(4'b1000, 4'b0000, ta, td);
    m_cur = pick();
    chk("ign_addr", addr_reg, 20'h12345);
    ta[1] = 20'h0ABCD;
    issue(4'b0010, 4'b0000, ta, td);
    chk("ign_busy_vec", cpu_busy, 4'b1010);
    serve(0, DW'($urandom), -1, gobs);
    serve(0, DW'($urandom), -1, gobs);

    // Timeout: no resolve, pulse exactly 255 cycles after entering WAIT
    saved = m_dout[1];
    ta[1] = AW'($urandom);
    issue(4'b0010, 4'b0000, ta, td);
    tick();
    chk("to_sched", schedule, 1);
    repeat (254) tick();
    chk("to_not_yet", cpu_ready, 0);
    chk("to_sched_held", schedule, 1);
    tick();
    chk("to_ready", cpu_ready, 4'b0010);
    chk("to_err", cpu_err, 4'b0010);
    chk("to_sched_drop", schedule, 0);
    chk("to_busy", cpu_busy, 0);
    chk("to_dout_kept", cpu_data_out[1], saved);
    m_pend[1] = 1'b0;
    m_ptr     = 2;
    tick();
    chk("to_ready_end", cpu_ready, 0);
    chk("to_err_end", cpu_err, 0);

    // Resolve on the timeout edge wins without error
    ta[2] = AW'($urandom);
    issue(4'b0100, 4'b0000, ta, td);
    serve(254, 16'hBEEF, -1, gobs);
    chk("to_edge_dout", cpu_data_out[2], 16'hBEEF);

    // Resolved while IDLE has no effect
    resolved = 1'b1;
    data_in  = 16'h7777;
    for (int t = 0; t < 3; t++) begin
      tick();
      chk("idle_res_sched", schedule, 0);
      chk("idle_res_ready", cpu_ready | cpu_err, 0);
    end
    resolved = 1'b0;
    check_dout();

    // Reset during WAIT clears immediately and leaves no stale response
    ta[2] = AW'($urandom);
    issue(4'b0100, 4'b0000, ta, td);
    tick();
    chk("rw_sched", schedule, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("rw_sched_now", schedule, 0);
    chk("rw_busy_now", cpu_busy, 0);
    chk("rw_ready_now", cpu_ready, 0);
    @(negedge clk);
    tick();
    reset = 1'b1;
    model_reset();
    for (int t = 0; t < 3; t++) begin
      tick();
      chk("rw_after_sched", schedule, 0);
      chk("rw_after_ready", cpu_ready, 0);
      chk("rw_after_busy", cpu_busy, 0);
    end
    check_dout();

    // Randomized batches against the model
    for (int b = 0; b < 25; b++) begin
      logic [N-1:0] mask;
      logic [N-1:0] wr;
      int n;
      mask = N'($urandom_range(1, 15));
      wr   = N'($urandom);
      for (int i = 0; i < N; i++) begin
        ta[i] = AW'($urandom);
        td[i] = DW'($urandom);
      end
      issue(mask, wr, ta, td);
      n = 0;
      while (m_pend != 0 && n < 40) begin
        serve(int'($urandom_range(0, 3)), DW'($urandom),
              (n < 3 && $urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3)) : -1, gobs);
        n++;
      end
      chk("rand_drained", cpu_busy, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
